// File: rtl/pipe_sequencer.sv
// pipe_sequencer: pipeline control sequencer (IDLE/RUN/FLUSH/STALL/HALT).
// Stage enables, PC load and NOP injection are decoded combinationally
// from the state register plus the current EX-stage inputs.
// Optional feature macro: PIPE_SEQUENCER_PERF_EN adds perf_cycles/perf_stalls.
module pipe_sequencer #(
    parameter int FLUSH_DEPTH = 2,
    parameter int MUL_LAT     = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        ex_valid,
    input  logic [15:0] ex_op,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        wb_en,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic        nop_inject,
    output logic        halted,
`ifdef PIPE_SEQUENCER_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_stalls,
`endif
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        STALL = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [15:0] OP_MUL     = 16'h1000;
    localparam logic [15:0] OP_HLT     = 16'h2000;
    localparam logic [3:0]  FLUSH_CNT  = 4'(FLUSH_DEPTH);
    localparam logic [3:0]  MUL_CNT    = 4'(MUL_LAT - 1);
    localparam logic        MUL_STALLS = (MUL_LAT > 1);

    state_t     cur;
    logic [3:0] cnt;

    // An EX event only counts when the slot is valid and the opcode is a
    // legal one-hot code; anything else behaves as a NOP.
    logic ev_ok, ev_hlt, ev_br, ev_mul;
    assign ev_ok  = ex_valid && $onehot(ex_op);
    assign ev_hlt = ev_ok && (ex_op == OP_HLT);
    assign ev_br  = ev_ok && !ev_hlt && branch_taken;
    assign ev_mul = ev_ok && !ev_hlt && !branch_taken && (ex_op == OP_MUL) && MUL_STALLS;

    // State register and shared flush/stall down-counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur <= IDLE;
            cnt <= 4'd0;
        end else begin
            case (cur)
                IDLE: if (start) cur <= RUN;
                RUN: begin
                    if (ev_hlt) begin
                        cur <= HALT;
                    end else if (ev_br) begin
                        cur <= FLUSH;
                        cnt <= FLUSH_CNT;
                    end else if (ev_mul) begin
                        cur <= STALL;
                        cnt <= MUL_CNT;
                    end
                end
                FLUSH, STALL: begin
                    if (cnt == 4'd1) begin
                        cur <= RUN;
                        cnt <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HALT:    cur <= HALT;
                default: cur <= IDLE;
            endcase
        end
    end

    // Output decode from state plus current EX inputs.
    always_comb begin
        fetch_en   = 1'b0;
        decode_en  = 1'b0;
        exec_en    = 1'b0;
        wb_en      = 1'b0;
        pc_load    = 1'b0;
        pc_value   = 32'd0;
        nop_inject = 1'b0;
        halted     = 1'b0;
        case (cur)
            RUN: begin
                fetch_en  = 1'b1;
                decode_en = 1'b1;
                exec_en   = 1'b1;
                // HLT and a stalling MUL both hold writeback for this cycle.
                wb_en     = !(ev_hlt || ev_mul);
                if (ev_br) begin
                    pc_load  = 1'b1;
                    pc_value = branch_target;
                end
            end
            FLUSH: begin
                fetch_en   = 1'b1;
                decode_en  = 1'b1;
                exec_en    = 1'b1;
                nop_inject = 1'b1;
            end
            STALL:   exec_en = 1'b1;
            HALT:    halted  = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

`ifdef PIPE_SEQUENCER_PERF_EN
    // Active-cycle and stall-cycle counters; they hold in IDLE and HALT.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_cycles <= 32'd0;
            perf_stalls <= 32'd0;
        end else begin
            if (cur == RUN || cur == FLUSH || cur == STALL)
                perf_cycles <= perf_cycles + 32'd1;
            if (cur == FLUSH || cur == STALL)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2, number of NOP-inject cycles after a taken branch (legal 1..7).
REQ-002 Parameter MUL_LAT, default 3, total EX cycles for MUL (legal 1..15); 1 means no stall.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level/pulse; leaves IDLE.
REQ-006 ex_valid  input  1  instruction in EX stage is valid.
REQ-007 ex_op  input  16  one-hot opcode of instruction in EX (ADD=0x0001 ... BNE=0x0200, MUL=0x1000, HLT=0x2000, NOP=0x4000).
REQ-008 branch_taken  input  1  EX resolved a taken BR/BNE this cycle.
REQ-009 branch_target  input  32  PC value of the taken branch.
REQ-010 fetch_en, decode_en, exec_en, wb_en  output  1 each  stage advance enables.
REQ-011 pc_load  output  1  load pc_value into PC this cycle.
REQ-012 pc_value  output  32  PC load value.
REQ-013 nop_inject  output  1  decoder substitutes opcode 0x4000 into ID_EX.
REQ-014 halted  output  1  sequencer in HALT.
REQ-015 state  output  3  encoded state: IDLE=0, RUN=1, FLUSH=2, STALL=3, HALT=4.

Function
REQ-016 State register and down-counter (3..4 bits) SHALL be the only sequential state besides perf counters; all outputs decoded from state plus current inputs.
REQ-017 IDLE: all enables 0, pc_load 0; start=1 -> RUN on next edge.
REQ-018 RUN: fetch_en=decode_en=exec_en=wb_en=1; nop_inject 0.
REQ-019 RUN event priority when ex_valid=1: HLT > branch_taken > MUL > none; only the highest event acts.
REQ-020 RUN, ex_op=0x2000: wb_en forced 0 that cycle; next state HALT.
REQ-021 RUN, branch_taken=1: pc_load=1 and pc_value=branch_target combinationally same cycle; next FLUSH, counter=FLUSH_DEPTH.
REQ-022 FLUSH: fetch_en=decode_en=exec_en=1, wb_en=0, nop_inject=1; counter decrements each cycle; counter==1 -> RUN; branch_taken/ex_op ignored.
REQ-023 RUN, ex_op=0x1000 and MUL_LAT>1: next STALL, counter=MUL_LAT-1; wb_en 0 that cycle.
REQ-024 STALL: fetch_en=decode_en=0, exec_en=1, wb_en=0; counter==1 -> RUN (wb_en=1 in first RUN cycle writes MUL result).
REQ-025 ex_valid=0, or ex_op not one-hot, SHALL cause no transition (treated as NOP).
REQ-026 HALT: all enables 0, halted=1, start ignored; exit only by reset.
REQ-027 pc_value SHALL read 0 whenever pc_load=0.

Reset
REQ-028 resetn=0 SHALL immediately force state IDLE, counter 0, all outputs 0, independent of clock, including mid-FLUSH/STALL.
REQ-029 First edge after resetn deasserts SHALL behave as IDLE.

Configuration
REQ-030 Macro PIPE_SEQUENCER_PERF_EN defined: outputs perf_cycles (32) counting cycles in RUN/FLUSH/STALL and perf_stalls (32) counting FLUSH+STALL cycles, both wrap at 2^32, cleared by reset, frozen in HALT/IDLE.
REQ-031 Macro undefined: perf ports and counters absent; all other behaviour identical.

Verification
REQ-032 Reset, start=1 one cycle -> state 1 next edge, all four enables 1.
REQ-033 RUN, ex_valid=1, branch_taken=1, branch_target=0x00000040 -> same cycle pc_load=1, pc_value=0x40; then exactly 2 cycles nop_inject=1, wb_en=0; then RUN.
REQ-034 RUN, ex_op=0x1000 (MUL_LAT=3) -> 2 STALL cycles with fetch_en=0, exec_en=1; wb_en=1 on return to RUN.
REQ-035 RUN, ex_op=0x2000 with branch_taken=1 same cycle -> no pc_load, halted=1 next edge; start=1 afterwards keeps HALT.
REQ-036 resetn low mid-FLUSH (counter=1) -> state 0, all outputs 0 before next clock edge.
REQ-037 With PIPE_SEQUENCER_PERF_EN: one branch plus one MUL in 10 RUN-state cycles -> perf_stalls=4, perf_cycles=14.
